// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port CPU memory.
// Optional misalignment trap enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              memRead,
  output logic              memWrite,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                gnt_d;
  logic                we_q;
  logic                mis_q;
  logic [3:0]          starve_cnt;
  logic                d_win;
  logic                mis;
  logic [DATA_W-1:0]   sel_addr;

  // Data wins unless fetch has been passed over STARVE_MAX times in a row.
  always_comb begin
    d_win    = d_req && (!i_req || (starve_cnt < 4'(STARVE_MAX)));
    sel_addr = d_win ? d_addr : i_addr;
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign mis = (sel_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt_d      <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      starve_cnt <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req)
            starve_cnt <= '0;
          if (i_req || d_req) begin
            gnt_d     <= d_win;
            we_q      <= d_win && d_we;
            mis_q     <= mis;
            mem_addr  <= sel_addr;
            mem_wdata <= d_win ? d_wdata : '0;
            memRead   <= !(d_win && d_we) && !mis;
            memWrite  <= d_win && d_we && !mis;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (d_win && i_req)
              starve_cnt <= starve_cnt + 4'd1;
            else if (!d_win)
              starve_cnt <= '0;
          end
        end
        ACCESS: begin
          memRead  <= 1'b0;
          memWrite <= 1'b0;
          if (gnt_d) begin
            if (!we_q && !mis_q)
              d_rdata <= mem_rdata;
            d_ack <= 1'b1;
            d_err <= mis_q;
          end else begin
            i_rdata <= mis_q ? '0 : mem_rdata;
            i_ack   <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 32-word behavioural memory.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        memRead;
  logic        memWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] mem [32];
  int          total;
  int          passed;
  int          errors;

  mem_arbiter #(.DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .memRead(memRead), .memWrite(memWrite), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk)
    if (memWrite) mem[mem_addr[6:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, i_ack, d_ack, d_err, memRead, memWrite, busy}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_irdata"}, i_rdata, 32'd0);
    check({tag, "_drdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int         n;
    total  = 0;
    passed = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[2] = 32'h0123_aefd;
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Fetch from word 2
    i_req = 1'b1; i_addr = 32'h8;
    tick();
    check("f_memread", {31'd0, memRead}, 32'd1);
    check("f_addr", mem_addr, 32'h8);
    check("f_early_ack", {31'd0, i_ack}, 32'd0);
    check("f_busy", {31'd0, busy}, 32'd1);
    tick();
    check("f_memread_off", {31'd0, memRead}, 32'd0);
    check("f_ack", {31'd0, i_ack}, 32'd1);
    check("f_rdata", i_rdata, 32'h0123_aefd);
    i_req = 1'b0;
    tick();
    check("f_ack_pulse", {31'd0, i_ack}, 32'd0);
    check("f_idle_busy", {31'd0, busy}, 32'd0);
    check("f_rdata_hold", i_rdata, 32'h0123_aefd);

    // Store then load at 0x4
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'habcd_dcba;
    tick();
    check("st_memwrite", {30'd0, memRead, memWrite}, 32'd1);
    check("st_wdata", mem_wdata, 32'habcd_dcba);
    tick();
    check("st_memwrite_off", {31'd0, memWrite}, 32'd0);
    check("st_ack", {30'd0, d_ack, d_err}, 32'b10);
    check("st_drdata_kept", d_rdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    d_req = 1'b1;
    tick();
    check("ld_memread", {30'd0, memRead, memWrite}, 32'b10);
    tick();
    check("ld_ack", {30'd0, d_ack, d_err}, 32'b10);
    check("ld_rdata", d_rdata, 32'habcd_dcba);
    check("ld_irdata_kept", i_rdata, 32'h0123_aefd);
    d_req = 1'b0;
    tick();

    // Both held: starvation guard ordering
    got = '0; n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    i_req = 1'b1; i_addr = 32'h8;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      tick();
      check("arb_rw_excl", {31'd0, memRead & memWrite}, 32'd0);
      check("arb_ack_excl", {31'd0, i_ack & d_ack}, 32'd0);
      if (d_ack || i_ack) begin
        got[n] = d_ack;
        n++;
      end
    end
    check("arb_count", n, 32'd8);
    check("arb_order", {24'd0, got}, 32'h77);
    check("arb_irdata", i_rdata, 32'h0123_aefd);
    check("arb_drdata", d_rdata, 32'habcd_dcba);
    d_req = 1'b0; i_req = 1'b0;
    tick();
    tick();

    // Reset during the ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hc; d_wdata = 32'hdead_beef;
    tick();
    check("rst_pre_write", {31'd0, memWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_all_zero("rst_held");
    check("rst_no_write", mem[3], 32'd0);
    reset = 1'b0;
    tick();
    check("rst_after1", {29'd0, busy, i_ack, d_ack}, 32'd0);
    tick();
    check("rst_after2", {29'd0, busy, i_ack, d_ack}, 32'd0);

    // Withdrawn request between edges
    d_addr = 32'h4;
    #2 d_req = 1'b1;
    #3 d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wd_quiet", {27'd0, memRead, memWrite, d_ack, i_ack, busy}, 32'd0);
    end

    // Misaligned load after a known-good load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    tick();
    tick();
    check("pre_mis_rdata", d_rdata, 32'h0123_aefd);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 32'h6;
    tick();
    check("mis_addr", mem_addr, 32'h6);
`ifdef MEM_ARB_ALIGN_CHECK_EN
    check("mis_memread", {30'd0, memRead, memWrite}, 32'b00);
    tick();
    check("mis_ack", {30'd0, d_ack, d_err}, 32'b11);
    check("mis_rdata", d_rdata, 32'h0123_aefd);
`else
    check("mis_memread", {30'd0, memRead, memWrite}, 32'b10);
    tick();
    check("mis_ack", {30'd0, d_ack, d_err}, 32'b10);
    check("mis_rdata", d_rdata, 32'habcd_dcba);
`endif
    d_req = 1'b0;
    tick();
    check("end_idle", {30'd0, busy, d_ack}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared single-port 32-word data/instruction memory of the multicycle CPU.
- Accepts requests from the instruction-fetch port (read only) and the load/store port (read/write).
- Grants one request at a time, drives the memory's memRead, memWrite, addr and data lines for exactly one access cycle, registers the read word, and returns a one-cycle ack.
- Data port has fixed priority, with a starvation guard for instruction fetch.

Parameters:
- DATA_W, 32, width of data and address buses.
- STARVE_MAX, 3, consecutive data grants allowed while i_req is pending before fetch is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request; held until i_ack.
- i_addr  input  DATA_W  fetch byte address.
- i_ack  output  1  one-cycle fetch completion.
- i_rdata  output  DATA_W  fetched word; valid when i_ack=1 and held until next fetch ack.
- d_req  input  1  load/store request; held until d_ack.
- d_we  input  1  1=store, 0=load.
- d_addr  input  DATA_W  load/store byte address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle load/store completion.
- d_rdata  output  DATA_W  loaded word; valid with d_ack.
- d_err  output  1  misalignment error; qualified by d_ack.
- memRead  output  1  memory read enable.
- memWrite  output  1  memory write enable.
- mem_addr  output  DATA_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; combinational from mem_addr.
- busy  output  1  high in ACCESS and RESP states.

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, mid-operation included.
  - State goes to IDLE; starve_cnt=0.
  - All outputs 0: i_ack, d_ack, d_err, memRead, memWrite, busy, mem_addr, mem_wdata, i_rdata, d_rdata.
  - A store in ACCESS when reset asserts is aborted; memWrite drops at once.
- FSM states:
  - IDLE: sample i_req and d_req.
    - Neither high: stay in IDLE.
    - Otherwise: latch winner (gnt_d), address, we and wdata, then go to ACCESS.
  - ACCESS, exactly 1 cycle:
    - mem_addr and mem_wdata come from latched registers.
    - memRead = ~we; memWrite = we.
    - At the end of the cycle, capture mem_rdata into the winner's rdata register (loads and fetches only), then go to RESP.
  - RESP, exactly 1 cycle:
    - Winner's ack=1. memRead=memWrite=0. mem_addr holds its value.
    - Go to IDLE.
- Latency and throughput: req high at edge k (in IDLE) gives ACCESS in cycle k..k+1 and ack in cycle k+1..k+2. One access per 3 cycles maximum.
- Handshake:
  - The requester keeps req and its fields stable until it samples ack=1, and must deassert req on that edge.
  - A req still high in the IDLE cycle after RESP counts as a new request.
  - A req dropped before grant is ignored, with no side effects.
- Arbitration, decided in IDLE only:
  - Only one req high: that port wins.
  - Both high and starve_cnt < STARVE_MAX: data wins, and starve_cnt increments (saturating).
  - Both high and starve_cnt == STARVE_MAX: fetch wins.
  - starve_cnt clears when fetch is granted, or in any IDLE cycle with i_req=0.
- rdata registers update only on a read by their own port. The other port's rdata is unchanged.
- Stores leave d_rdata unchanged.
- d_err=0 unless ALIGN_CHECK_EN is defined.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - A granted request with addr[1:0] != 2'b00 skips the memory access: memRead=memWrite=0 during ACCESS.
  - The error is still acked in RESP with the same latency.
  - Data port: d_err=1 on that d_ack, and d_rdata is unchanged.
  - Fetch port: i_rdata = 32'h0000_0000 (NOP).
- Undefined: no check is made. Addresses pass through unmodified, and d_err is tied 0.

Test Plan:
- Reset then i_req=1 with i_addr=32'h0000_0008 (memory word 2 = 32'h0123_aefd):
  - memRead=1 exactly one cycle.
  - i_ack at the 2nd edge after request.
  - i_rdata=32'h0123_aefd.
- Store then load at the same address:
  - d_req with d_we=1, d_addr=32'h4, d_wdata=32'habcd_dcba gives memWrite=1 for one cycle, then d_ack with d_err=0.
  - Follow-up load at d_addr=32'h4 returns d_rdata=32'habcd_dcba.
- Both i_req and d_req held continuously, STARVE_MAX=3:
  - Grant order is D,D,D,I,D,D,D,I.
  - No cycle has memRead and memWrite both high.
  - The acks never overlap.
- Reset mid-store:
  - Assert reset during the ACCESS cycle of a store of 32'hdead_beef.
  - memWrite falls immediately, and all outputs read 0 while reset is high.
  - After reset, state is IDLE with no ack pending.
- Request withdrawal: d_req pulses high for 0 cycles at an IDLE edge (rises and falls between edges) → no grant, no memRead/memWrite, no ack.
- With MEM_ARB_ALIGN_CHECK_EN defined, d_req load at d_addr=32'h6:
  - memRead stays 0.
  - d_ack=1 with d_err=1.
  - d_rdata keeps its previous value.
- With MEM_ARB_ALIGN_CHECK_EN undefined, the same load gives a normal read and d_err=0.
